// File: rtl/dpd_lut_pingpong.sv
// rtl/dpd_lut_pingpong.sv - multi-channel DPD LUT with ping-pong banks, global swap and clear engine
module dpd_lut_pingpong #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          NUM_LUTS     = 4,
  parameter logic [15:0] ID_MASK      = 16'hffff,
  parameter int          SWAP_TIMEOUT = 1024,
  parameter int          SEL_WIDTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_LUTS*ADDR_WIDTH-1:0] lut_addr,
  input  logic                           lut_addr_valid,
  output logic [NUM_LUTS*DATA_WIDTH-1:0] lut_out,
  output logic                           lut_out_valid,
  input  logic [SEL_WIDTH-1:0]           cfg_sel,
  input  logic [ADDR_WIDTH-1:0]          cfg_addr,
  input  logic [DATA_WIDTH-1:0]          cfg_wdata,
  input  logic                           cfg_wr,
  input  logic                           cfg_rd,
  input  logic                           cfg_rd_active,
  output logic [DATA_WIDTH-1:0]          cfg_rdata,
  output logic                           cfg_rvalid,
  input  logic                           cfg_clear,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           active_bank,
  output logic                           cfg_busy,
  output logic                           cfg_err
);
  typedef enum logic [1:0] {IDLE, SWAP_PEND, CLEAR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_LAST    = '1;
  localparam logic [31:0]           LP_TO_LAST = 32'(SWAP_TIMEOUT) - 32'd1;

  state_t                r_state;
  logic                  r_active_bank;
  logic                  r_pend;
  logic                  r_swap_ack;
  logic                  r_cfg_err;
  logic                  r_rvalid;
  logic                  r_out_valid;
  logic [31:0]           r_wait;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [SEL_WIDTH-1:0]  r_clr_sel;
  logic [NUM_LUTS-1:0]   r_rd_hit;

  logic                  w_idle;
  logic                  w_clearing;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_err;
  logic                  w_force;
  logic                  w_swap_now;
  logic [ADDR_WIDTH:0]   w_b_addr;
  logic [DATA_WIDTH-1:0] w_b_wdata;
  logic [NUM_LUTS-1:0]   w_sel_hit;
  logic [DATA_WIDTH-1:0] w_qb [NUM_LUTS];
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_idle     = (r_state == IDLE);
  assign w_clearing = (r_state == CLEAR);
  assign w_wr_acc   = w_idle && cfg_wr;
  assign w_rd_acc   = cfg_rd && ((w_idle && !cfg_wr) || (r_state == SWAP_PEND));
  assign w_force    = (SWAP_TIMEOUT != 0) && (r_wait == LP_TO_LAST);
  assign w_swap_now = (r_state == SWAP_PEND) && (!lut_addr_valid || w_force);

  always_comb begin
    w_err = 1'b0;
    case (r_state)
      IDLE:      w_err = cfg_wr && cfg_rd;
      SWAP_PEND: w_err = cfg_wr || cfg_clear;
      default:   w_err = cfg_wr || cfg_clear || cfg_rd;
    endcase
  end

  // Port B: clear engine owns it in CLEAR; writes always hit the shadow bank
  assign w_b_addr  = w_clearing ? {~r_active_bank, r_cnt}
                   : {(w_rd_acc && cfg_rd_active) ? r_active_bank : ~r_active_bank, cfg_addr};
  assign w_b_wdata = w_clearing ? '0 : cfg_wdata;

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    localparam logic [SEL_WIDTH-1:0] LP_IDX = SEL_WIDTH'(i);
    if (ID_MASK[i]) begin : g_ram
      logic [DATA_WIDTH-1:0] r_mem [2**(ADDR_WIDTH+1)];
      logic [DATA_WIDTH-1:0] r_qa;
      logic [DATA_WIDTH-1:0] r_qb;
      logic [ADDR_WIDTH-1:0] w_addr_a;
      logic                  w_b_we;

      assign w_addr_a     = lut_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_sel_hit[i] = (cfg_sel == LP_IDX);
      assign w_b_we       = (w_wr_acc && w_sel_hit[i]) || (w_clearing && (r_clr_sel == LP_IDX));

      always_ff @(posedge clk) begin
        if (w_b_we) r_mem[w_b_addr] <= w_b_wdata;
        if (w_rd_acc) r_qb <= r_mem[w_b_addr];
        if (rst) r_qa <= '0;
        else if (lut_addr_valid) r_qa <= r_mem[{r_active_bank, w_addr_a}];
      end

      assign w_qb[i]                            = r_qb;
      assign lut_out[i*DATA_WIDTH +: DATA_WIDTH] = r_qa;
    end else begin : g_zero
      assign w_sel_hit[i]                        = 1'b0;
      assign w_qb[i]                             = '0;
      assign lut_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  // r_rd_hit only moves on accepted reads, so cfg_rdata holds between reads
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_LUTS; i++) begin
      if (r_rd_hit[i]) w_rdata = w_rdata | w_qb[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_active_bank <= 1'b0;
      r_pend        <= 1'b0;
      r_wait        <= '0;
      r_cnt         <= '0;
      r_clr_sel     <= '0;
      r_swap_ack    <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_out_valid   <= 1'b0;
      r_rd_hit      <= '0;
    end else begin
      r_swap_ack  <= 1'b0;
      r_cfg_err   <= w_err;
      r_rvalid    <= w_rd_acc;
      r_out_valid <= lut_addr_valid;
      if (w_rd_acc) r_rd_hit <= w_sel_hit;
      case (r_state)
        IDLE: begin
          if (cfg_clear) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_clr_sel <= cfg_sel;
            r_pend    <= swap_req;
          end else if (swap_req) begin
            r_state <= SWAP_PEND;
            r_wait  <= '0;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (swap_req) r_pend <= 1'b1;
          if (r_cnt == LP_LAST) begin
            r_pend  <= 1'b0;
            r_wait  <= '0;
            r_state <= (r_pend || swap_req) ? SWAP_PEND : IDLE;
          end
        end
        SWAP_PEND: begin
          if (w_swap_now) begin
            r_active_bank <= ~r_active_bank;
            r_swap_ack    <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lut_out_valid = r_out_valid;
  assign cfg_rdata     = w_rdata;
  assign cfg_rvalid    = r_rvalid;
  assign swap_ack      = r_swap_ack;
  assign active_bank   = r_active_bank;
  assign cfg_busy      = !w_idle;
  assign cfg_err       = r_cfg_err;
endmodule

// File: tb/tb_dpd_lut_pingpong.sv
// tb/tb_dpd_lut_pingpong.sv - randomized bench for dpd_lut_pingpong against a behavioural model
module tb_dpd_lut_pingpong;
  localparam int          DW    = 32;
  localparam int          AW    = 10;
  localparam int          NL    = 4;
  localparam int          TO    = 32;
  localparam int          SW    = 4;
  localparam logic [15:0] MASK  = 16'hfffd;
  localparam int          DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NL*AW-1:0] lut_addr;
  logic             lut_addr_valid;
  logic [NL*DW-1:0] lut_out;
  logic             lut_out_valid;
  logic [SW-1:0]    cfg_sel;
  logic [AW-1:0]    cfg_addr;
  logic [DW-1:0]    cfg_wdata;
  logic             cfg_wr, cfg_rd, cfg_rd_active;
  logic [DW-1:0]    cfg_rdata;
  logic             cfg_rvalid, cfg_clear, swap_req, swap_ack, active_bank, cfg_busy, cfg_err;

  always #5 clk = ~clk;

  dpd_lut_pingpong #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LUTS(NL), .ID_MASK(MASK),
    .SWAP_TIMEOUT(TO), .SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .lut_addr(lut_addr), .lut_addr_valid(lut_addr_valid),
    .lut_out(lut_out), .lut_out_valid(lut_out_valid), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_rd_active(cfg_rd_active), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .cfg_clear(cfg_clear), .swap_req(swap_req), .swap_ack(swap_ack),
    .active_bank(active_bank), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: mem[lut][bank][addr]; mode 0 idle, 1 swap pending, 2 clearing
  logic [DW-1:0] m_mem [NL][2][DEPTH];
  int            m_mode, m_wait, m_idx, m_clr;
  logic          m_bank, m_pend;
  logic [NL*DW-1:0] e_out;
  logic          e_vld, e_rvalid, e_ack, e_err;
  logic [DW-1:0] e_rdata;

  function automatic bit en(input int s);
    return (s < NL) && (MASK[s] == 1'b1);
  endfunction

  function automatic logic [DW-1:0] rd_val(input int s, input logic b, input logic [AW-1:0] a);
    return en(s) ? m_mem[s][b][a] : '0;
  endfunction

  task automatic chk(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic nb;
    e_ack = 1'b0; e_err = 1'b0; e_rvalid = 1'b0;
    if (rst) begin
      m_mode = 0; m_bank = 1'b0; m_pend = 1'b0; m_wait = 0; m_idx = 0;
      e_out = '0; e_vld = 1'b0; e_rdata = '0;
      return;
    end
    if (lut_addr_valid)
      for (int i = 0; i < NL; i++) e_out[i*DW +: DW] = rd_val(i, m_bank, lut_addr[i*AW +: AW]);
    e_vld = lut_addr_valid;
    nb = m_bank;
    case (m_mode)
      0: begin
        if (cfg_wr) begin
          if (en(int'(cfg_sel))) m_mem[cfg_sel][!m_bank][cfg_addr] = cfg_wdata;
          e_err = cfg_rd;
        end else if (cfg_rd) begin
          e_rvalid = 1'b1;
          e_rdata  = rd_val(int'(cfg_sel), cfg_rd_active ? m_bank : !m_bank, cfg_addr);
        end
        if (cfg_clear) begin
          m_mode = 2; m_clr = int'(cfg_sel); m_idx = 0; m_pend = swap_req;
        end else if (swap_req) begin
          m_mode = 1; m_wait = 0;
        end
      end
      1: begin
        e_err = cfg_wr || cfg_clear;
        if (cfg_rd) begin
          e_rvalid = 1'b1;
          e_rdata  = rd_val(int'(cfg_sel), cfg_rd_active ? m_bank : !m_bank, cfg_addr);
        end
        if (!lut_addr_valid || m_wait == TO - 1) begin
          nb = !m_bank; e_ack = 1'b1; m_mode = 0;
        end else m_wait++;
      end
      default: begin
        e_err = cfg_wr || cfg_clear || cfg_rd;
        if (en(m_clr)) m_mem[m_clr][!m_bank][m_idx] = '0;
        if (swap_req) m_pend = 1'b1;
        m_idx++;
        if (m_idx == DEPTH) begin
          m_mode = m_pend ? 1 : 0; m_pend = 1'b0; m_wait = 0;
        end
      end
    endcase
    m_bank = nb;
  endtask

  task automatic compare();
    chk("lut_out", lut_out, e_out);
    chk("lut_out_valid", lut_out_valid, e_vld);
    chk("cfg_rvalid", cfg_rvalid, e_rvalid);
    chk("cfg_rdata", cfg_rdata, e_rdata);
    chk("swap_ack", swap_ack, e_ack);
    chk("active_bank", active_bank, m_bank);
    chk("cfg_busy", cfg_busy, m_mode != 0);
    chk("cfg_err", cfg_err, e_err);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic quiet();
    lut_addr = '0; lut_addr_valid = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_rd_active = 1'b0; cfg_clear = 1'b0; swap_req = 1'b0;
  endtask

  task automatic rand_addr();
    for (int i = 0; i < NL; i++) lut_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
  endtask

  task automatic cfg_write(input int s, input int a, input logic [DW-1:0] d);
    cfg_sel = SW'(s); cfg_addr = AW'(a); cfg_wdata = d; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input int s, input int a, input logic act);
    cfg_sel = SW'(s); cfg_addr = AW'(a); cfg_rd_active = act; cfg_rd = 1'b1;
    tick();
    cfg_rd = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && cfg_busy; k++) tick();
    chk("wait_idle_timeout", cfg_busy, 1'b0);
  endtask

  task automatic clear_only(input int s);
    cfg_sel = SW'(s); cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    wait_idle();
  endtask

  task automatic clear_and_swap(input int s);
    int  nb;
    bit  ack;
    ack = 1'b0;
    cfg_sel = SW'(s); cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    nb = cfg_busy ? 1 : 0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    if (cfg_busy) nb++;
    for (int k = 0; k < 2000 && cfg_busy; k++) begin
      tick();
      if (cfg_busy) nb++;
      else ack = swap_ack;
    end
    chk("clear_swap_busy_len", 32'(nb), 32'd1025);
    chk("clear_swap_ack", ack, 1'b1);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic b0;
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_active_bank", active_bank, 1'b0);
    chk("reset_busy", cfg_busy, 1'b0);
    chk("reset_lut_out", lut_out, '0);
    chk("reset_rvalid", cfg_rvalid, 1'b0);

    clear_only(0);
    clear_only(3);
    clear_and_swap(2);
    chk("clear_swap_bank", active_bank, 1'b1);
    lut_addr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_addr();
      tick();
      chk("cleared_lut2_zero", lut_out[2*DW +: DW], '0);
    end
    lut_addr_valid = 1'b0;
    clear_only(0);
    clear_only(3);
    clear_and_swap(2);
    chk("init_bank_back", active_bank, 1'b0);

    // basic swap
    cfg_write(3, 5, 32'h12345678);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    chk("basic_swap_ack", swap_ack, 1'b1);
    chk("basic_swap_bank", active_bank, 1'b1);
    lut_addr = '0; lut_addr[3*AW +: AW] = AW'(5); lut_addr_valid = 1'b1;
    tick();
    lut_addr_valid = 1'b0;
    chk("basic_lut3_data", lut_out[3*DW +: DW], 32'h12345678);
    chk("basic_lut3_valid", lut_out_valid, 1'b1);

    // disabled slot
    cfg_write(1, 7, 32'hdeadbeef);
    chk("disabled_wr_err", cfg_err, 1'b0);
    cfg_read(1, 7, 1'b0);
    chk("disabled_rdata", cfg_rdata, '0);
    chk("disabled_rvalid", cfg_rvalid, 1'b1);
    chk("disabled_rd_err", cfg_err, 1'b0);
    lut_addr[1*AW +: AW] = AW'(7); lut_addr_valid = 1'b1;
    tick();
    lut_addr_valid = 1'b0;
    chk("disabled_lut_out", lut_out[1*DW +: DW], '0);

    // write and read together in IDLE
    cfg_sel = SW'(0); cfg_addr = AW'(9); cfg_wdata = 32'ha5a5c3c3; cfg_wr = 1'b1; cfg_rd = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    chk("wr_rd_err", cfg_err, 1'b1);
    chk("wr_rd_no_rvalid", cfg_rvalid, 1'b0);
    cfg_read(0, 9, 1'b0);
    chk("wr_rd_write_landed", cfg_rdata, 32'ha5a5c3c3);

    // gated swap
    lut_addr_valid = 1'b1; rand_addr(); swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_addr();
      tick();
      if (swap_ack) seen = 1'b1;
    end
    chk("gated_no_early_ack", seen, 1'b0);
    lut_addr_valid = 1'b0;
    tick();
    chk("gated_ack_on_gap", swap_ack, 1'b1);

    // forced swap
    lut_addr_valid = 1'b1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n = 0;
    while (!swap_ack && n < 200) begin
      rand_addr();
      tick();
      n++;
    end
    chk("forced_swap_latency", 32'(n), 32'(TO));
    lut_addr_valid = 1'b0;
    tick();

    // write during clear is dropped
    cfg_write(3, 20, 32'h0badf00d);
    cfg_sel = SW'(0); cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_write(3, 20, 32'hffffffff);
    chk("clear_wr_err", cfg_err, 1'b1);
    wait_idle();
    cfg_read(3, 20, 1'b0);
    chk("clear_wr_unchanged", cfg_rdata, 32'h0badf00d);

    // reset while swap pending
    if (m_bank) begin
      swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
    end
    b0 = active_bank;
    chk("pre_reset_bank", b0, 1'b0);
    lut_addr_valid = 1'b1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; lut_addr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (swap_ack) seen = 1'b1;
    end
    chk("reset_cancel_no_ack", seen, 1'b0);
    chk("reset_cancel_bank", active_bank, 1'b0);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      lut_addr_valid = ($urandom_range(0, 1) == 1);
      rand_addr();
      cfg_sel       = SW'($urandom_range(0, 5));
      cfg_addr      = AW'($urandom_range(0, 15));
      cfg_wdata     = $urandom;
      cfg_wr        = ($urandom_range(0, 3) == 0);
      cfg_rd        = ($urandom_range(0, 3) == 0);
      cfg_rd_active = ($urandom_range(0, 1) == 1);
      swap_req      = ($urandom_range(0, 39) == 0);
      cfg_clear     = ($urandom_range(0, 799) == 0);
      tick();
    end
    quiet();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
